decode_stage: RTL and testbench
===============================

# decode_stage

Registered, parametrised instruction decode stage for the 16-bit RISC core, sitting between fetch and execute. It splits each instruction into opcode, register and immediate fields and derives the control strobes. It adds three things combinational decode lacks: a valid/ready handshake on both sides, a register scoreboard that stalls on RAW/WAW hazards until writeback, and a jump-shadow state that holds fetch off until the branch is resolved.

## Interface
Parameters:
- REG_AW, 3: register address width; NREG = 2**REG_AW.
- INS_W, 3+3*REG_AW (12): instruction width.
- IMM_W, 8: immediate width; imm = ins[INS_W-1 -: IMM_W].

Ports:
- clk  in  1  clock; everything is rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- ins_valid  in  1  fetch offers an instruction.
- ins_ready  out  1  decode accepts this cycle.
- ins  in  INS_W  instruction: op=[2:0], d=[3+:REG_AW], s1=[3+REG_AW+:REG_AW], s2=[3+2*REG_AW+:REG_AW].
- dec_valid  out  1  decoded bundle held.
- dec_ready  in  1  execute takes bundle.
- op  out  3;  d, s1, s2  out  REG_AW;  imm  out  IMM_W  registered fields.
- jc, lc, dwc, rwc  out  1  jump, load, data-write, register-write strobes.
- wb_valid  in  1  writeback completing.
- wb_d  in  REG_AW  register being written back.
- flush  in  1  branch resolved; discard held bundle, leave jump shadow.

## Operation
- Strobes: jc = (op==110); lc = (op==011); dwc = (op==101); rwc = 1 except for op 110 and op 101.
- Scoreboard: NREG busy bits. A bit is set at issue (dec_valid & dec_ready & rwc) for the issued d. It is cleared by wb_valid for wb_d. When set and clear hit the same register in the same cycle, set wins. A wb to a non-busy register is ignored.
- Hazard for an incoming instruction, where busy' = scoreboard with this cycle's wb clear applied (same-cycle bypass):
  - RAW: when op≠110, s1 or s2 is busy', or s1/s2 equals the held bundle's d while the held bundle has rwc=1 and is not issuing this cycle.
  - WAW: when rwc=1, d is busy', or d equals that held d under the same condition.
- ins_ready = rst_n & state==RUN & !hazard & (!dec_valid | dec_ready) & !flush.
- FSM:
  - RUN: accepting an instruction with jc=1 moves to JWAIT.
  - JWAIT: ins_ready=0. Held bundles still drain. flush returns to RUN.
  - flush in RUN has no state effect.
- flush clears dec_valid next cycle, regardless of dec_ready. The scoreboard is untouched, because unissued bundles never set bits. If dec_valid & dec_ready & flush occur together, the issue counts: the scoreboard is set and the bundle is consumed.

## Timing
- Latency: 1 cycle from ins accept to dec_valid. Throughput: 1/cycle absent hazards and backpressure.
- Bundle outputs are stable while dec_valid & !dec_ready.
- Reset values: dec_valid=0; op/d/s1/s2/imm=0; jc/lc/dwc=0; rwc=0 (forced low while !dec_valid); scoreboard all 0; state RUN.
- Reset mid-operation discards the held bundle and all busy bits on the next edge.
- A wb in cycle N unblocks a dependent instruction in cycle N (bypass), with accept at that edge.
- Register addresses wrap naturally mod NREG. There is no special register 0.

## Structure
- Shared package holds:
  - opcode constants OP_LD=3'b011, OP_ST=3'b101, OP_JMP=3'b110;
  - the field offset functions of REG_AW;
  - the state enum {RUN, JWAIT}.
- One sub-module, decode_scoreboard(NREG): set/clear ports, busy vector out, set-over-clear priority.
- Field slicing and strobe logic stay inline.

## Test plan
- Back-to-back independent ALU ops (op=000, d=1,2,3; sources 4..7), dec_ready=1 -> three bundles on consecutive cycles, rwc=1, busy bits 1,2,3 set.
- Load to d=2, then an op with s1=2 -> ins_ready=0 until wb_valid with wb_d=2. The dependent op is accepted in that same cycle and dec_valid rises the next cycle.
- Store (op=101) -> dwc=1, rwc=0, no busy bit set. A following reader of the store's d field is not stalled.
- Jump (op=110) accepted -> ins_ready=0 for 5 cycles despite ins_valid. flush in cycle 6 -> ins_ready=1 the next cycle, held bundle dropped.
- dec_ready=0 for 4 cycles with a bundle held -> fields constant and no new accept. dec_ready=1 -> issue, then the next instruction is accepted the same cycle.
- rst_n=0 while busy bits {2,5} are set and dec_valid=1 -> after one edge dec_valid=0, scoreboard=0, state RUN.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, field offsets, stage state.
// Imported by the decode stage and its testbench.
package decode_pkg;

  localparam logic [2:0] OP_LD  = 3'b011;
  localparam logic [2:0] OP_ST  = 3'b101;
  localparam logic [2:0] OP_JMP = 3'b110;

  typedef enum logic {RUN, JWAIT} state_t;

  // idx 0 = d, 1 = s1, 2 = s2; fields sit above the 3-bit opcode
  function automatic int f_lo(input int aw, input int idx);
    return 3 + idx * aw;
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Register busy bits for the decode stage.
// Set at issue, cleared at writeback; set wins on collision.
module decode_scoreboard #(
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set,
  input  logic [AW-1:0]   set_d,
  input  logic            clr,
  input  logic [AW-1:0]   clr_d,
  output logic [NREG-1:0] busy
);

  logic [NREG-1:0] set_m;
  logic [NREG-1:0] clr_m;

  always_comb begin
    set_m = '0;
    clr_m = '0;
    if (set) set_m[set_d] = 1'b1;
    if (clr) clr_m[clr_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy <= '0;
    else        busy <= (busy & ~clr_m) | set_m;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with handshakes, hazard scoreboard
// and a jump shadow that holds fetch off until flush.
module decode_stage
  import decode_pkg::*;
#(
  parameter int REG_AW = 3,
  parameter int INS_W  = 3 + 3 * REG_AW,
  parameter int IMM_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ins_valid,
  output logic              ins_ready,
  input  logic [INS_W-1:0]  ins,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [2:0]        op,
  output logic [REG_AW-1:0] d,
  output logic [REG_AW-1:0] s1,
  output logic [REG_AW-1:0] s2,
  output logic [IMM_W-1:0]  imm,
  output logic              jc,
  output logic              lc,
  output logic              dwc,
  output logic              rwc,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_d,
  input  logic              flush
);

  localparam int NREG  = 2 ** REG_AW;
  localparam int D_LO  = f_lo(REG_AW, 0);
  localparam int S1_LO = f_lo(REG_AW, 1);
  localparam int S2_LO = f_lo(REG_AW, 2);

  logic [2:0]        i_op;
  logic [REG_AW-1:0] i_d;
  logic [REG_AW-1:0] i_s1;
  logic [REG_AW-1:0] i_s2;
  logic              i_jc;
  logic              i_lc;
  logic              i_dwc;
  logic              i_rwc;

  assign i_op = ins[2:0];
  assign i_d  = ins[D_LO +: REG_AW];
  assign i_s1 = ins[S1_LO +: REG_AW];
  assign i_s2 = ins[S2_LO +: REG_AW];

  always_comb begin
    i_jc  = 1'b0;
    i_lc  = 1'b0;
    i_dwc = 1'b0;
    unique case (1'b1)
      i_op == OP_JMP: i_jc  = 1'b1;
      i_op == OP_LD:  i_lc  = 1'b1;
      i_op == OP_ST:  i_dwc = 1'b1;
      default: ;
    endcase
  end

  assign i_rwc = ~(i_jc | i_dwc);

  state_t            state;
  state_t            state_n;
  logic              rwc_q;
  logic              issue;
  logic              accept;
  logic              held_w;
  logic              raw;
  logic              waw;
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_b;

  assign issue  = dec_valid & dec_ready;
  assign held_w = dec_valid & rwc_q & ~issue;
  assign rwc    = dec_valid & rwc_q;

  decode_scoreboard #(.NREG(NREG)) u_sb (
    .clk   (clk),
    .rst_n (rst_n),
    .set   (issue & rwc_q),
    .set_d (d),
    .clr   (wb_valid),
    .clr_d (wb_d),
    .busy  (busy)
  );

  // same-cycle writeback bypass
  always_comb begin
    busy_b = busy;
    if (wb_valid) busy_b[wb_d] = 1'b0;
  end

  assign raw = ~i_jc & (busy_b[i_s1] | busy_b[i_s2]
             | (held_w & ((i_s1 == d) | (i_s2 == d))));
  assign waw = i_rwc & (busy_b[i_d] | (held_w & (i_d == d)));

  assign ins_ready = rst_n & (state == RUN) & ~raw & ~waw
                   & (~dec_valid | dec_ready) & ~flush;
  assign accept = ins_valid & ins_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      RUN:   if (accept && i_jc) state_n = JWAIT;
      JWAIT: if (flush) state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dec_valid <= 1'b0;
      op        <= '0;
      d         <= '0;
      s1        <= '0;
      s2        <= '0;
      imm       <= '0;
      jc        <= 1'b0;
      lc        <= 1'b0;
      dwc       <= 1'b0;
      rwc_q     <= 1'b0;
    end else begin
      if (flush)       dec_valid <= 1'b0;
      else if (accept) dec_valid <= 1'b1;
      else if (issue)  dec_valid <= 1'b0;
      if (accept) begin
        op    <= i_op;
        d     <= i_d;
        s1    <= i_s1;
        s2    <= i_s2;
        imm   <= ins[INS_W-1 -: IMM_W];
        jc    <= i_jc;
        lc    <= i_lc;
        dwc   <= i_dwc;
        rwc_q <= i_rwc;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage against a transaction-level
// model of held bundle, busy set and jump shadow.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ins_valid;
  logic        ins_ready;
  logic [11:0] ins;
  logic        dec_valid;
  logic        dec_ready;
  logic [2:0]  op;
  logic [2:0]  d;
  logic [2:0]  s1;
  logic [2:0]  s2;
  logic [7:0]  imm;
  logic        jc;
  logic        lc;
  logic        dwc;
  logic        rwc;
  logic        wb_valid;
  logic [2:0]  wb_d;
  logic        flush;

  decode_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready),
    .ins       (ins),
    .dec_valid (dec_valid),
    .dec_ready (dec_ready),
    .op        (op),
    .d         (d),
    .s1        (s1),
    .s2        (s2),
    .imm       (imm),
    .jc        (jc),
    .lc        (lc),
    .dwc       (dwc),
    .rwc       (rwc),
    .wb_valid  (wb_valid),
    .wb_d      (wb_d),
    .flush     (flush)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // model: held instruction word, busy set, jump-shadow flag
  bit [7:0]  m_busy;
  bit        m_hv;
  bit [11:0] m_hins;
  bit        m_jw;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] mk(input logic [2:0] o,
      input logic [2:0] rd, input logic [2:0] a, input logic [2:0] b);
    return {b, a, rd, o};
  endfunction

  function automatic bit writes(input bit [2:0] o);
    return !(o == 3'b101 || o == 3'b110);
  endfunction

  // ready can only rise when any held bundle is leaving, so only
  // the busy set (after this cycle's writeback) can block it
  function automatic bit exp_ready();
    bit [7:0] nb;
    bit [2:0] o, rd, a, b;
    bit haz;
    if (!rst_n || m_jw || flush) return 1'b0;
    if (m_hv && !dec_ready) return 1'b0;
    nb = m_busy;
    if (wb_valid) nb[wb_d] = 1'b0;
    {b, a, rd, o} = ins;
    haz = (o != 3'b110 && (nb[a] || nb[b])) || (writes(o) && nb[rd]);
    return !haz;
  endfunction

  task automatic model_step(input bit rdy);
    bit acc, iss;
    if (!rst_n) begin
      m_busy = '0;
      m_hv   = 1'b0;
      m_hins = '0;
      m_jw   = 1'b0;
    end else begin
      iss = m_hv && dec_ready;
      acc = ins_valid && rdy;
      if (wb_valid) m_busy[wb_d] = 1'b0;
      if (iss && writes(m_hins[2:0])) m_busy[m_hins[5:3]] = 1'b1;
      if (m_jw) m_jw = !flush;
      else      m_jw = acc && ins[2:0] == 3'b110;
      if (flush) m_hv = 1'b0;
      else if (acc) begin
        m_hv   = 1'b1;
        m_hins = ins;
      end else if (iss) m_hv = 1'b0;
    end
  endtask

  task automatic check_outputs();
    bit [2:0] o;
    o = m_hins[2:0];
    chk("dec_valid", dec_valid, m_hv);
    chk("fields", {op, d, s1, s2, imm},
        {o, m_hins[5:3], m_hins[8:6], m_hins[11:9], m_hins[11:4]});
    chk("strobes", {jc, lc, dwc, rwc},
        {o == 3'b110, o == 3'b011, o == 3'b101, m_hv && writes(o)});
    chk("busy", dut.u_sb.busy, m_busy);
  endtask

  task automatic cyc(input bit iv, input logic [11:0] in_i,
                     input bit dr, input bit wv, input logic [2:0] wd,
                     input bit fl);
    bit er;
    ins_valid = iv;
    ins       = in_i;
    dec_ready = dr;
    wb_valid  = wv;
    wb_d      = wd;
    flush     = fl;
    #2;
    er = exp_ready();
    chk("ins_ready", ins_ready, er);
    @(posedge clk);
    model_step(er);
    #1;
    check_outputs();
  endtask

  task automatic idle(input bit dr);
    cyc(1'b0, 12'h0, dr, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic wb(input logic [2:0] r);
    cyc(1'b0, 12'h0, 1'b1, 1'b1, r, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    ins_valid = 1'b0;
    ins = '0;
    dec_ready = 1'b0;
    wb_valid = 1'b0;
    wb_d = '0;
    flush = 1'b0;
    @(posedge clk);
    model_step(1'b0);
    #1;
    check_outputs();
    idle(1'b0);
    rst_n = 1'b1;

    // independent ALU ops back to back
    cyc(1'b1, mk(3'd0, 3'd1, 3'd4, 3'd5), 1'b1, 1'b0, 3'd0, 1'b0);
    cyc(1'b1, mk(3'd0, 3'd2, 3'd6, 3'd7), 1'b1, 1'b0, 3'd0, 1'b0);
    cyc(1'b1, mk(3'd0, 3'd3, 3'd4, 3'd7), 1'b1, 1'b0, 3'd0, 1'b0);
    idle(1'b1);
    chk("busy_123", dut.u_sb.busy, 8'h0E);
    wb(3'd1);
    wb(3'd2);
    wb(3'd3);

    // load then dependent reader, released by same-cycle writeback
    cyc(1'b1, mk(3'b011, 3'd2, 3'd0, 3'd0), 1'b1, 1'b0, 3'd0, 1'b0);
    idle(1'b1);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, mk(3'd0, 3'd4, 3'd2, 3'd0), 1'b1, 1'b0, 3'd0, 1'b0);
    chk("raw_stall", ins_ready, 1'b0);
    cyc(1'b1, mk(3'd0, 3'd4, 3'd2, 3'd0), 1'b1, 1'b1, 3'd2, 1'b0);
    chk("dep_held", {dec_valid, d}, {1'b1, 3'd4});
    idle(1'b1);
    wb(3'd4);

    // store sets no busy bit, reader of its d is not stalled
    cyc(1'b1, mk(3'b101, 3'd6, 3'd1, 3'd1), 1'b1, 1'b0, 3'd0, 1'b0);
    cyc(1'b1, mk(3'd0, 3'd5, 3'd6, 3'd6), 1'b1, 1'b0, 3'd0, 1'b0);
    idle(1'b1);
    chk("busy_st", dut.u_sb.busy, 8'h20);
    wb(3'd5);

    // jump shadow held until flush; held jump dropped
    cyc(1'b1, mk(3'b110, 3'd0, 3'd0, 3'd0), 1'b0, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 5; i++)
      cyc(1'b1, mk(3'd0, 3'd1, 3'd0, 3'd0), 1'b0, 1'b0, 3'd0, 1'b0);
    cyc(1'b1, mk(3'd0, 3'd1, 3'd0, 3'd0), 1'b0, 1'b0, 3'd0, 1'b1);
    chk("jmp_drop", dec_valid, 1'b0);
    cyc(1'b1, mk(3'd0, 3'd1, 3'd0, 3'd0), 1'b1, 1'b0, 3'd0, 1'b0);
    idle(1'b1);
    wb(3'd1);

    // backpressure: fields frozen, then issue and accept together
    cyc(1'b1, mk(3'd0, 3'd1, 3'd2, 3'd3), 1'b1, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc(1'b1, mk(3'd0, 3'd5, 3'd6, 3'd7), 1'b0, 1'b0, 3'd0, 1'b0);
    cyc(1'b1, mk(3'd0, 3'd5, 3'd6, 3'd7), 1'b1, 1'b0, 3'd0, 1'b0);
    chk("bp_next", d, 3'd5);
    idle(1'b1);
    wb(3'd1);
    wb(3'd5);

    // reset mid-operation with busy {2,5} and a held bundle
    cyc(1'b1, mk(3'd0, 3'd2, 3'd0, 3'd0), 1'b1, 1'b0, 3'd0, 1'b0);
    cyc(1'b1, mk(3'd0, 3'd5, 3'd0, 3'd0), 1'b1, 1'b0, 3'd0, 1'b0);
    cyc(1'b1, mk(3'd0, 3'd7, 3'd0, 3'd0), 1'b1, 1'b0, 3'd0, 1'b0);
    idle(1'b0);
    chk("pre_rst", {dec_valid, dut.u_sb.busy}, {1'b1, 8'h24});
    rst_n = 1'b0;
    idle(1'b0);
    chk("post_rst", {dec_valid, dut.u_sb.busy}, 9'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 2000; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      cyc($urandom_range(0, 3) != 0, 12'($urandom),
          $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
          3'($urandom),
          m_jw ? ($urandom_range(0, 3) == 0)
               : ($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
